// File: rtl/led_flasher_pkg.sv
// Shared types and helpers for the LED flasher: FSM state encoding and ms-to-cycles conversion.
package led_flasher_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF} flash_state_t;

  // 64-bit math so large ms * Hz products do not overflow before the divide.
  function automatic longint ms_to_ticks(input longint ms, input longint clkfreq);
    return ms * clkfreq / 1000;
  endfunction

endpackage

// File: rtl/led_flasher_if.sv
// Request/status bundle between a flash requester (master) and the flasher (slave).
interface led_flasher_if #(
  parameter int COUNT_W = 4
);
  logic               start;
  logic [COUNT_W-1:0] count;
  logic               led;
  logic               busy;
  logic               done;

  modport master (output start, count, input  led, busy, done);
  modport slave  (input  start, count, output led, busy, done);
endinterface

// File: rtl/led_flasher_tick_timer.sv
// Cycle counter that runs 0..TICKS-1 while enabled and pulses tc on the last count.
// tc is combinational from the count so the FSM can act on it in the same cycle.
module tick_timer #(
  parameter int TICKS = 1,
  parameter int W     = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/led_flasher.sv
// Flashes the LED count times (ON_MS lit, OFF_MS dark each) after an accepted start.
// Outputs registered; start is ignored while busy, done pulses in the first non-busy cycle.
module led_flasher
  import led_flasher_pkg::*;
#(
  parameter int CLKPD_NS = 10,
  parameter int CLKFREQ  = 1_000_000_000 / CLKPD_NS,
  parameter int ON_MS    = 250,
  parameter int OFF_MS   = 250,
  parameter int COUNT_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  led_flasher_if.slave  bus
);

  localparam int ON_TICKS  = int'(ms_to_ticks(longint'(ON_MS), longint'(CLKFREQ)));
  localparam int OFF_TICKS = int'(ms_to_ticks(longint'(OFF_MS), longint'(CLKFREQ)));
  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMR_W     = $clog2(MAX_TICKS + 1);

  if (ON_TICKS < 1 || OFF_TICKS < 1) begin : g_tick_check
    $error("led_flasher: ON_TICKS and OFF_TICKS must both be at least 1");
  end

  flash_state_t       state;
  logic [COUNT_W-1:0] remaining;
  logic               led_q;
  logic               busy_q;
  logic               done_q;
  logic               on_tc;
  logic               off_tc;

  // Each timer is held cleared outside its own phase, so it always enters at zero.
  tick_timer #(.TICKS(ON_TICKS), .W(TMR_W)) u_on_tmr (
    .clk (clk),
    .clr (rst || state != ON),
    .en  (state == ON),
    .tc  (on_tc)
  );

  tick_timer #(.TICKS(OFF_TICKS), .W(TMR_W)) u_off_tmr (
    .clk (clk),
    .clr (rst || state != OFF),
    .en  (state == OFF),
    .tc  (off_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.count != '0) begin
            remaining <= bus.count;
            state     <= ON;
            led_q     <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ON: begin
          if (on_tc) begin
            state <= OFF;
            led_q <= 1'b0;
          end
        end
        OFF: begin
          if (off_tc) begin
            remaining <= remaining - COUNT_W'(1);
            if (remaining == COUNT_W'(1)) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= ON;
              led_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_led_flasher.sv
// Bench for led_flasher: fixed-timing table, hand-written corner sequences and random traffic.
module tb_led_flasher;

  localparam int ON_T  = 8;   // 1 ms at 8 kHz
  localparam int OFF_T = 16;  // 2 ms at 8 kHz
  localparam int PER   = ON_T + OFF_T;

  typedef struct {
    int rel;
    bit led;
    bit busy;
    bit done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  led_flasher_if #(.COUNT_W(4)) bus ();

  led_flasher #(
    .CLKPD_NS (10),
    .CLKFREQ  (8000),
    .ON_MS    (1),
    .OFF_MS   (2),
    .COUNT_W  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks        = 0;
  int fails         = 0;
  int cyc           = 0;
  int done_seen     = 0;
  int busy_cnt      = 0;
  int last_done_cyc = -1;

  // Reference model: one active request described by acceptance cycle and flash count.
  bit m_active = 1'b0;
  int m_acc    = 0;
  int m_n      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model(input int t, output bit e_led, output bit e_busy, output bit e_done);
    int rel;
    e_led  = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (m_active) begin
      rel = t - m_acc - 1;
      if (rel >= 0) begin
        e_busy = rel < m_n * PER;
        e_led  = e_busy && ((rel % PER) < ON_T);
        e_done = rel == m_n * PER;
      end
    end
  endfunction

  // Checks the current cycle against the model, then drives this cycle's inputs.
  task automatic tick(input bit st, input logic [3:0] cnt, input bit r);
    bit el, eb, ed;
    model(cyc, el, eb, ed);
    check("led", 32'(bus.led), 32'(el));
    check("busy", 32'(bus.busy), 32'(eb));
    check("done", 32'(bus.done), 32'(ed));
    if (bus.done === 1'b1) begin
      done_seen++;
      last_done_cyc = cyc;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    bus.start = st;
    bus.count = cnt;
    rst       = r;
    if (r)
      m_active = 1'b0;
    else if (st && cnt != 4'd0 && !eb) begin
      m_active = 1'b1;
      m_acc    = cyc;
      m_n      = int'(cnt);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    vec_t tbl[14];
    int   base;
    int   d0;
    int   b0;

    tbl[0]  = '{0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b0};
    tbl[2]  = '{8,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{9,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{24, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{25, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{32, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{33, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{49, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{56, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{57, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{72, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{73, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{74, 1'b0, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.count = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(bus.led), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_remaining", 32'(dut.remaining), 32'd0);

    // count=3 against fixed expected waveform points
    base = cyc;
    for (int r = 0; r <= 80; r++) begin
      foreach (tbl[i]) begin
        if (tbl[i].rel == r) begin
          check("tbl_led", 32'(bus.led), 32'(tbl[i].led));
          check("tbl_busy", 32'(bus.busy), 32'(tbl[i].busy));
          check("tbl_done", 32'(bus.done), 32'(tbl[i].done));
        end
      end
      tick(r == 0, 4'd3, 1'b0);
    end
    check("s1_done_cyc", 32'(last_done_cyc - base), 32'd73);

    // count=0 is ignored
    b0 = busy_cnt;
    d0 = done_seen;
    for (int r = 0; r <= 100; r++) tick(r == 0, 4'd0, 1'b0);
    check("s2_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    check("s2_done_pulses", 32'(done_seen - d0), 32'd0);

    // start while busy is discarded
    base = cyc;
    d0   = done_seen;
    for (int r = 0; r <= 60; r++) tick(r == 0 || r == 10, (r == 0) ? 4'd2 : 4'd5, 1'b0);
    check("s3_done_cyc", 32'(last_done_cyc - base), 32'd49);
    check("s3_done_pulses", 32'(done_seen - d0), 32'd1);

    // restart in the done cycle
    base = cyc;
    d0   = done_seen;
    for (int r = 0; r <= 60; r++) tick(r == 0 || r == 25, 4'd1, 1'b0);
    check("s4_done_cyc", 32'(last_done_cyc - base), 32'd50);
    check("s4_done_pulses", 32'(done_seen - d0), 32'd2);

    // reset mid-flash suppresses done; a later request still works
    d0 = done_seen;
    for (int r = 0; r <= 230; r++) tick(r == 0, 4'd4, r == 30);
    check("s5_done_after_rst", 32'(done_seen - d0), 32'd0);
    d0 = done_seen;
    for (int r = 0; r <= 60; r++) tick(r == 0, 4'd2, 1'b0);
    check("s5_restart_done", 32'(done_seen - d0), 32'd1);

    // maximum count
    b0 = busy_cnt;
    d0 = done_seen;
    for (int r = 0; r <= 365; r++) tick(r == 0, 4'd15, 1'b0);
    check("s6_busy_cycles", 32'(busy_cnt - b0), 32'd360);
    check("s6_done_pulses", 32'(done_seen - d0), 32'd1);
    check("s6_remaining", 32'(dut.remaining), 32'd0);

    // random traffic against the model
    for (int r = 0; r < 3000; r++) begin
      tick($urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 599) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
